// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared types, constants and popcount helper for the popcount display controller
package popcount_pkg;

    // Accumulator width; WORDS <= 42 keeps the worst-case total (252) inside it.
    localparam int ACC_W = 8;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex digit to segment pattern, bit order gfedcba, active-high.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Number of set bits in a 6-bit word (0..6).
    function automatic logic [2:0] popcount6(input logic [5:0] word);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 6; i++) begin
            cnt = cnt + {2'b00, word[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational hex nibble to 7-segment lookup
module seg7_hex_decoder
    import popcount_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure table lookup; the caller registers the result.
    assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/popcount_seq_ctrl.sv
// rtl/popcount_seq_ctrl.sv - burst popcount accumulator with multiplexed 7-segment display
module popcount_seq_ctrl
    import popcount_pkg::*;
#(
    parameter int WORDS      = 4,
    parameter int DIGIT_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] data_in,
    input  logic       data_valid,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy,
    output logic       done
);

    // Terminal counts compared against the 8-bit counters.
    localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);
    localparam logic [7:0] HOLD_LAST = 8'(DIGIT_HOLD - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [ACC_W-1:0]   r_acc;
    logic [7:0]         r_word_cnt;
    logic [7:0]         r_hold_cnt;
    logic               r_nib_sel;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_busy;
    logic               r_done;

    logic               w_start_burst;
    logic               w_last_word;
    logic               w_take_word;
    logic               w_show_stay;
    logic [2:0]         w_pop;
    logic [3:0]         w_nibble;
    logic [6:0]         w_hex;
    logic [6:0]         w_seg_next;
    logic               w_dp_next;
    logic               w_busy_next;
    logic               w_done_next;

    assign w_pop    = popcount6(data_in);
    assign w_nibble = r_nib_sel ? r_acc[7:4] : r_acc[3:0];

    seg7_hex_decoder u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_hex)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the values the output registers load next.
    always_comb begin
        w_next_state  = r_state;
        w_start_burst = 1'b0;
        w_last_word   = 1'b0;
        w_take_word   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // data_valid is deliberately ignored here, even alongside start.
                if (start) begin
                    w_next_state  = ST_ACCUM;
                    w_start_burst = 1'b1;
                end
            end
            ST_ACCUM: begin
                // start has no effect mid-burst.
                if (data_valid) begin
                    w_take_word = 1'b1;
                    if (r_word_cnt == LAST_WORD) begin
                        w_next_state = ST_SHOW;
                        w_last_word  = 1'b1;
                    end
                end
            end
            ST_SHOW: begin
                if (start) begin
                    w_next_state  = ST_ACCUM;
                    w_start_burst = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // The display reflects this cycle's SHOW state one cycle later, and
        // blanks straight away when a restart leaves SHOW.
        w_show_stay = (r_state == ST_SHOW) && (w_next_state == ST_SHOW);
        w_seg_next  = w_show_stay ? w_hex : SEG_BLANK;
        w_dp_next   = w_show_stay & r_nib_sel;
        w_busy_next = (w_next_state == ST_ACCUM);
        w_done_next = w_last_word;
    end

    // Burst accumulator and word counter, cleared at every burst start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_word_cnt <= 8'd0;
        end else if (w_start_burst) begin
            r_acc      <= '0;
            r_word_cnt <= 8'd0;
        end else if (w_take_word) begin
            r_acc      <= r_acc + {5'b00000, w_pop};
            r_word_cnt <= r_word_cnt + 8'd1;
        end
    end

    // Nibble hold timer; held at zero outside SHOW so every entry starts on the low nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
            r_nib_sel  <= 1'b0;
        end else if (r_state != ST_SHOW) begin
            r_hold_cnt <= 8'd0;
            r_nib_sel  <= 1'b0;
        end else if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= 8'd0;
            r_nib_sel  <= ~r_nib_sel;
        end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    // Registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg  <= SEG_BLANK;
            r_dp   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_seg  <= w_seg_next;
            r_dp   <= w_dp_next;
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

    assign seg  = r_seg;
    assign dp   = r_dp;
    assign busy = r_busy;
    assign done = r_done;

endmodule
